// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-master memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_I    = 2'd1,
        OWNER_D    = 2'd2
    } arb_owner_e;

    localparam int DEFAULT_BURST_LEN = 4;

    // The counter must be able to hold BURST_LEN itself, not just BURST_LEN-1.
    function automatic int beat_cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

    localparam int BEAT_CNT_W = beat_cnt_width(DEFAULT_BURST_LEN);

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between the I-side and D-side requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise D always wins ties.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       last_served_i,
    output arb_owner_e winner
);

    always_comb begin
        winner = OWNER_NONE;
        if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            winner = last_served_i ? OWNER_D : OWNER_I;
`else
            winner = OWNER_D;
`endif
        end else if (i_req) begin
            winner = OWNER_I;
        end else if (d_req) begin
            winner = OWNER_D;
        end
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_ptr;
    assign unused_ptr = last_served_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one burst memory port between the I-cache and D-cache; one owner per burst.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: D-side priority).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_read,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_resp,
    output logic                    i_error,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_address,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_resp,
    output logic                    d_error,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp,
    input  logic                    pm_error
);

    localparam int CNT_W = beat_cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_e              state_reg;
    logic [CNT_W-1:0]        beat_cnt_reg;
    logic                    mem_read_reg;
    logic                    mem_write_reg;
    logic [ADDR_WIDTH-1:0]   mem_address_reg;
    logic                    i_error_reg;
    logic                    d_error_reg;

    logic       own_i;
    logic       own_d;
    logic       grant_end;
    logic       d_req;
    logic       d_conflict;
    logic       last_served_i;
    arb_owner_e winner;

    assign own_i      = (state_reg == GRANT_I);
    assign own_d      = (state_reg == GRANT_D);
    // A D-side request is only legal with exactly one of read/write raised.
    assign d_conflict = d_read && d_write;
    assign d_req      = d_read ^ d_write;
    assign grant_end  = (own_i || own_d) &&
                        (pm_error || (mem_resp && (beat_cnt_reg == LAST_BEAT)));

    mem_arb_picker u_picker (
        .i_req         (i_read),
        .d_req         (d_req),
        .last_served_i (last_served_i),
        .winner        (winner)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_served_i_reg;

    // Reset value marks I as last served so the first tie goes to D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served_i_reg <= 1'b1;
        end else if (grant_end) begin
            last_served_i_reg <= own_i;
        end
    end

    assign last_served_i = last_served_i_reg;
`else
    assign last_served_i = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            beat_cnt_reg    <= '0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            i_error_reg     <= 1'b0;
            d_error_reg     <= 1'b0;
        end else begin
            i_error_reg <= 1'b0;
            d_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    beat_cnt_reg <= '0;
                    d_error_reg  <= d_conflict;
                    if (winner == OWNER_I) begin
                        state_reg       <= GRANT_I;
                        mem_read_reg    <= 1'b1;
                        mem_write_reg   <= 1'b0;
                        mem_address_reg <= i_address;
                    end else if (winner == OWNER_D) begin
                        state_reg       <= GRANT_D;
                        mem_read_reg    <= d_read;
                        mem_write_reg   <= d_write;
                        mem_address_reg <= d_address;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (grant_end) begin
                        state_reg       <= RELEASE;
                        mem_read_reg    <= 1'b0;
                        mem_write_reg   <= 1'b0;
                        mem_address_reg <= '0;
                        beat_cnt_reg    <= pm_error ? '0 : beat_cnt_reg + CNT_W'(1);
                        i_error_reg     <= pm_error && own_i;
                        d_error_reg     <= pm_error && own_d;
                    end else if (mem_resp) begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    state_reg    <= IDLE;
                    beat_cnt_reg <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Beats reach only the owner, in the same cycle as mem_resp.
    assign i_resp          = own_i && mem_resp;
    assign d_resp          = own_d && mem_resp;
    assign i_rdata         = i_resp ? mem_rdata : '0;
    assign d_rdata         = d_resp ? mem_rdata : '0;
    assign i_error         = i_error_reg;
    assign d_error         = d_error_reg;
    assign mem_read        = mem_read_reg;
    assign mem_write       = mem_write_reg;
    assign mem_address     = mem_address_reg;
    assign mem_wdata       = own_d ? d_wdata : '0;
    assign mem_byte_enable = own_d ? d_byte_enable : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter sharing the single burst memory port between the instruction-fetch cache (I-side, read-only) and the data cache (D-side, read/write). It sits between the caches and the memory model/controller on `mem_itf`. It latches the winner's command and address for the whole burst, counts response beats, and routes beats and errors back to the owner only. After every transaction it forces one idle cycle so the memory never sees a back-to-back request as a continuation.

## Interface
- `BURST_LEN`, default 4: response beats per transaction.
- `DATA_WIDTH`, default 32: beat width; byte enables are `DATA_WIDTH/8`.
- `ADDR_WIDTH`, default 32: address width.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst_n  in  1`: reset, asynchronous assert, active-low.
- `i_read  in  1`: I-side read request.
- `i_address  in  ADDR_WIDTH`: I-side address.
- `i_rdata  out  DATA_WIDTH`: I-side read beat.
- `i_resp  out  1`: I-side beat valid.
- `i_error  out  1`: I-side transaction aborted.
- `d_read`, `d_write  in  1`: D-side requests.
- `d_address  in  ADDR_WIDTH`: D-side address.
- `d_wdata  in  DATA_WIDTH`: D-side write beat.
- `d_byte_enable  in  DATA_WIDTH/8`: D-side strobes.
- `d_rdata  out  DATA_WIDTH`: D-side read beat.
- `d_resp  out  1`: D-side beat valid.
- `d_error  out  1`: D-side transaction aborted.
- `mem_read`, `mem_write  out  1`: memory command.
- `mem_address  out  ADDR_WIDTH`: latched address.
- `mem_wdata  out  DATA_WIDTH`: write beat.
- `mem_byte_enable  out  DATA_WIDTH/8`: write strobes.
- `mem_rdata  in  DATA_WIDTH`: memory read beat.
- `mem_resp  in  1`: memory beat valid.
- `pm_error  in  1`: memory protocol error.

## Operation
- States:
  - IDLE: no transaction; arbitration happens here.
  - GRANT_I: I-side owns the port.
  - GRANT_D: D-side owns the port.
  - RELEASE: one forced idle cycle after a transaction.
- IDLE arbitration:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both request: apply the priority policy (see Configuration).
- On grant, latch the command (read or write) and address into registers. `mem_address`, `mem_read` and `mem_write` are driven only from these registers, so they stay constant even if the owner changes its inputs.
- `d_read && d_write` together in IDLE: not granted; `d_error` pulses for 1 cycle; state stays IDLE.
- GRANT_x:
  - Each `mem_resp`-high cycle increments the beat counter, width `$clog2(BURST_LEN+1)`.
  - Each such beat copies `mem_rdata` to the owner's rdata and pulses the owner's resp.
  - The non-owner's resp and rdata stay 0.
  - `mem_wdata` and `mem_byte_enable` pass through combinationally from the D-side and are 0 when the I-side owns the port.
  - Transition to RELEASE on the cycle after beat BURST_LEN is counted.
- `pm_error` during a grant: pulse the owner's error for 1 cycle, clear the counter, go to RELEASE.
- RELEASE: `mem_read`/`mem_write` low and counter cleared, then IDLE.
- Requesters must drop their request in the cycle after their last resp. A request still high in IDLE is treated as a new transaction.
- Extra `mem_resp` in IDLE or RELEASE: ignored, no resp forwarded.

## Timing
- Reset values: every output 0, state IDLE, counter 0, priority pointer set to favour D.
- Latency:
  - Request high at edge N gives `mem_read`/`mem_write` high from edge N+1.
  - Owner resp is combinational from `mem_resp` (0 extra cycles).
- Minimum gap between transactions: RELEASE (1 cycle) plus IDLE (1 cycle).
- Reset asserted mid-burst: outputs drop to 0 immediately, no error pulse, and the partial burst is discarded.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-served pointer decides ties; the master not served last wins.
  - The pointer updates only when a grant completes or aborts.
  - Either master waits at most one transaction.
- Undefined: fixed priority, D-side always wins ties. Pointer logic is absent.

## Structure
- `mem_arb_pkg` holds:
  - `arb_state_e` (IDLE, GRANT_I, GRANT_D, RELEASE);
  - `arb_owner_e` (OWNER_NONE, OWNER_I, OWNER_D);
  - localparam `BEAT_CNT_W`.
- One sub-module, `mem_arb_picker`: combinational, inputs are the two requests plus the pointer, output is the winner. It contains the `MEM_ARB_ROUND_ROBIN_EN` ifdef.

## Test plan
- I read 0x0000_0040 alone, 4 beats 0x11..0x44: the same 4 values appear on `i_rdata` with `i_resp`, `mem_address` is constant, and `mem_read` drops on the cycle after beat 4.
- I and D read together, fixed priority: D is served first, then I starts exactly 2 cycles after D's last beat. With `MEM_ARB_ROUND_ROBIN_EN` and D last served: I first.
- D write 0x1100_0000, be=4'b0011: `mem_write` stays high for 4 beats, `mem_byte_enable`=0011, `i_resp` is never asserted.
- `pm_error` after beat 2 of an I read: `i_error` pulses 1 cycle, RELEASE, then IDLE, and the next D request is granted.
- `rst_n` low during beat 3: all outputs 0 immediately, and the next read after reset completes a full 4 beats.
- `d_read`=`d_write`=1: `d_error` pulses 1 cycle and `mem_read`/`mem_write` stay 0.
